perip_arbiter: RTL
==================

PERIP_ARBITER -- requirements
Module: perip_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, meaning cycles from perip_addr valid to perip_rdata valid; legal 1..4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req / m1_req  input  1  requester 0 (CPU data port) / requester 1 (DMA/debug) access request.
REQ-005 m0_addr / m1_addr  input  32  byte address.
REQ-006 m0_wen / m1_wen  input  1  1 = store, 0 = load.
REQ-007 m0_mask / m1_mask  input  2  size: 00 byte, 01 half, 11 word.
REQ-008 m0_wdata / m1_wdata  input  32  store data.
REQ-009 m0_gnt / m1_gnt  output  1  combinational accept; request taken at the edge where req&&gnt.
REQ-010 m0_rvalid / m1_rvalid  output  1  one-cycle pulse, load data valid.
REQ-011 rdata  output  32  load data, shared, qualified by mN_rvalid.
REQ-012 perip_addr  output  32  registered downstream address.
REQ-013 perip_wen  output  1  registered downstream write strobe.
REQ-014 perip_mask  output  2  registered downstream size.
REQ-015 perip_wdata  output  32  registered downstream store data.
REQ-016 perip_rdata  input  32  downstream raw read data.

Function
REQ-017 FSM states IDLE, WR, RD; grants SHALL be issued only in IDLE.
REQ-018 IDLE, one req: that requester gnt=1 same cycle.
REQ-019 IDLE, both req: round-robin; grant the requester not granted last; last-grant pointer updates on every accepted request.
REQ-020 At most one gnt high in any cycle; gnt=0 in WR and RD.
REQ-021 On accept: winner addr/wen/mask/wdata latched into perip_* registers; mask 10 forwarded as 11.
REQ-022 Accepted store -> WR for exactly 1 cycle, perip_wen=1 only in that cycle, then IDLE.
REQ-023 Accepted load -> RD for exactly RD_LAT cycles, perip_wen=0, perip_addr/mask held stable.
REQ-024 Last RD cycle: perip_rdata captured into rdata; owner's rvalid=1 in the following cycle (IDLE), exactly one cycle.
REQ-025 Load latency: gnt edge T -> rvalid high in cycle T+RD_LAT+1; store: perip_wen high in cycle T+1.
REQ-026 rdata holds value until next load capture; rvalid to the non-owner SHALL stay 0.
REQ-027 IDLE cycle carrying rvalid SHALL still accept a new request (back-to-back loads every RD_LAT+1 cycles, stores every 2).
REQ-028 perip_wen SHALL be 0 in IDLE and RD; perip_addr holds last value in IDLE.
REQ-029 req deasserted before gnt: no access, pointer unchanged; requester holds req/addr/wen/mask/wdata stable until gnt.
REQ-030 Requester owning an in-flight load may re-request; new request arbitrates normally in IDLE.
REQ-031 Address passed unmodified (no alignment check, no lane steering; sign/zero extension done by consumer).

Reset
REQ-032 rst_n low: state IDLE, pointer = last-granted m1 (m0 wins first tie), perip_addr=0, perip_wen=0, perip_mask=00, perip_wdata=0, rdata=0, all rvalid=0.
REQ-033 Reset mid-WR or mid-RD aborts immediately: perip_wen drops asynchronously, no rvalid issued for the aborted load.
REQ-034 First grant possible in first cycle after rst_n deasserts.

Verification
REQ-035 Single store: m0 req, addr 0x0000_0104, wdata 0xDEAD_BEEF, mask 11 -> m0_gnt same cycle, next cycle perip_wen=1, perip_addr=0x104, perip_wdata=0xDEADBEEF, then perip_wen=0.
REQ-036 Load, RD_LAT=2: m1 load addr 0x200, perip_rdata=0x1234_5678 in RD -> m1_rvalid exactly 3 cycles after gnt edge, rdata=0x12345678, m0_rvalid=0.
REQ-037 Contention: both req continuously after reset -> grant order m0,m1,m0,m1; never two gnt together; no starvation over 16 grants.
REQ-038 Back-to-back: m0 load then immediate m1 store, RD_LAT=1 -> m1_gnt in the same cycle m0_rvalid=1; perip_wen=1 the next cycle.
REQ-039 Reset during RD (RD_LAT=4, cycle 2) -> all outputs at reset values, no rvalid after rst_n release; fresh request completes normally.
REQ-040 Illegal mask 10 on store -> perip_mask=11 during WR.

Source files
------------

// File: rtl/perip_arbiter.sv
// perip_arbiter: two-requester round-robin arbiter feeding one registered peripheral port
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : requester ports (req, addr, wen, mask, wdata in; gnt, rvalid out)
//   rdata               : shared load data, qualified by m0_rvalid / m1_rvalid
//   perip_addr/wen/mask/wdata : registered downstream access
//   perip_rdata         : raw downstream read data, sampled in the last RD cycle
module perip_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [1:0]  m0_mask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [1:0]  m1_mask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic [31:0] perip_addr,
  output logic        perip_wen,
  output logic [1:0]  perip_mask,
  output logic [31:0] perip_wdata,
  input  logic [31:0] perip_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
  logic [1:0]  state;
  logic [1:0]  cnt;
  logic        last;
  logic        owner;
  logic        idle;
  logic        acc;
  logic        sel;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_wen;
  logic [1:0]  a_mask;
  assign idle = state == IDLE;
  // on a tie the requester that was not granted last wins; last=1 means m1 won last
  assign m0_gnt = idle & m0_req & (~m1_req | last);
  assign m1_gnt = idle & m1_req & (~m0_req | ~last);
  assign acc = m0_gnt | m1_gnt;
  assign sel = m1_gnt;
  always_comb begin
    a_addr  = sel ? m1_addr  : m0_addr;
    a_wdata = sel ? m1_wdata : m0_wdata;
    a_wen   = sel ? m1_wen   : m0_wen;
    a_mask  = sel ? m1_mask  : m0_mask;
    // the reserved size code is treated as a word access
    a_mask  = (a_mask == 2'b10) ? 2'b11 : a_mask;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      last        <= 1'b1;
      owner       <= 1'b0;
      perip_addr  <= 32'd0;
      perip_wen   <= 1'b0;
      perip_mask  <= 2'b00;
      perip_wdata <= 32'd0;
      rdata       <= 32'd0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (acc) begin
        state       <= a_wen ? WR : RD;
        cnt         <= LAT_M1;
        last        <= sel;
        owner       <= sel;
        perip_addr  <= a_addr;
        perip_wen   <= a_wen;
        perip_mask  <= a_mask;
        perip_wdata <= a_wdata;
      end else if (state == WR) begin
        state     <= IDLE;
        perip_wen <= 1'b0;
      end else if (state == RD) begin
        if (cnt == 2'd0) begin
          state     <= IDLE;
          rdata     <= perip_rdata;
          m0_rvalid <= ~owner;
          m1_rvalid <= owner;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end
endmodule
